// File: rtl/pc_stage.sv
// Fetch PC generation with an optional gshare/BTB predictor and the PC/IF pipeline register.
// Define PC_STAGE_BRANCH_PREDICT_EN to build the predictor; otherwise fetch is purely sequential.
module pc_stage #(
    parameter int          GHR_WIDTH       = 5,
    parameter int          BTB_INDEX_WIDTH = 6,
    parameter logic [31:0] RESET_PC        = 32'hBFC00000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 is_branch_in,
    input  logic                 is_jump_in,
    input  logic                 is_taken_in,
    input  logic                 is_miss_in,
    input  logic [GHR_WIDTH-1:0] last_pht_index,
    input  logic [31:0]          inst_pc,
    input  logic [31:0]          target_in,
    input  logic                 flush,
    input  logic [31:0]          exc_pc,
    input  logic                 stall,
    output logic                 is_branch_taken,
    output logic [GHR_WIDTH-1:0] pht_index_out,
    output logic [31:0]          pc_out,
    output logic                 if_is_branch_taken,
    output logic [GHR_WIDTH-1:0] if_pht_index,
    output logic [31:0]          if_pc
);

    logic [31:0]          pc_q;
    logic [31:0]          pc_next;
    logic                 predict_taken;
    logic [GHR_WIDTH-1:0] lookup_index;
    logic [31:0]          predict_target;

    assign pc_out          = pc_q;
    assign is_branch_taken = predict_taken;
    assign pht_index_out   = lookup_index;

`ifdef PC_STAGE_BRANCH_PREDICT_EN
    localparam int PHT_DEPTH = 2 ** GHR_WIDTH;
    localparam int BTB_DEPTH = 2 ** BTB_INDEX_WIDTH;
    localparam int TAG_WIDTH = 30 - BTB_INDEX_WIDTH;

    logic [GHR_WIDTH-1:0]       ghr;
    logic [1:0]                 pht [PHT_DEPTH];
    logic [BTB_DEPTH-1:0]       btb_valid;
    logic [BTB_DEPTH-1:0]       btb_jump;
    logic [TAG_WIDTH-1:0]       btb_tag [BTB_DEPTH];
    logic [31:0]                btb_target [BTB_DEPTH];

    logic [BTB_INDEX_WIDTH-1:0] fetch_slot;
    logic [BTB_INDEX_WIDTH-1:0] update_slot;
    logic                       btb_hit;
    logic [1:0]                 fetch_counter;
    logic [1:0]                 update_counter;
    logic [1:0]                 update_counter_next;
    logic                       pht_update;
    logic                       btb_update;

    // Lookup reads only registered state, so a same-cycle update is seen one cycle later.
    assign fetch_slot     = pc_q[BTB_INDEX_WIDTH+1:2];
    assign lookup_index   = ghr ^ pc_q[GHR_WIDTH+1:2];
    assign btb_hit        = btb_valid[fetch_slot] &&
                            (btb_tag[fetch_slot] == pc_q[31:BTB_INDEX_WIDTH+2]);
    assign fetch_counter  = pht[lookup_index];
    assign predict_taken  = btb_hit && (btb_jump[fetch_slot] || fetch_counter[1]);
    assign predict_target = btb_target[fetch_slot];

    assign update_slot    = inst_pc[BTB_INDEX_WIDTH+1:2];
    assign update_counter = pht[last_pht_index];
    assign pht_update     = is_branch_in && !is_jump_in;
    assign btb_update     = is_branch_in && is_taken_in;

    always_comb begin
        update_counter_next = update_counter;
        if (is_taken_in) begin
            if (update_counter != 2'd3) update_counter_next = update_counter + 2'd1;
        end else begin
            if (update_counter != 2'd0) update_counter_next = update_counter - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ghr       <= '0;
            btb_valid <= '0;
            for (int i = 0; i < PHT_DEPTH; i++) pht[i] <= 2'b01;
        end else begin
            if (pht_update) begin
                pht[last_pht_index] <= update_counter_next;
                ghr                 <= {ghr[GHR_WIDTH-2:0], is_taken_in};
            end
            if (btb_update) btb_valid[update_slot] <= 1'b1;
        end
    end

    // Payload fields are qualified by btb_valid and need no reset.
    always_ff @(posedge clk) begin
        if (btb_update) begin
            btb_tag[update_slot]    <= inst_pc[31:BTB_INDEX_WIDTH+2];
            btb_target[update_slot] <= target_in;
            btb_jump[update_slot]   <= is_jump_in;
        end
    end
`else
    localparam int unused_btb_index_width = BTB_INDEX_WIDTH;
    logic unused_predictor_inputs;

    assign unused_predictor_inputs = ^{is_branch_in, is_jump_in, last_pht_index};
    assign predict_taken  = 1'b0;
    assign lookup_index   = '0;
    assign predict_target = '0;
`endif

    always_comb begin
        pc_next = pc_q + 32'd4;
        if (flush) begin
            pc_next = exc_pc;
        end else if (is_miss_in) begin
            pc_next = is_taken_in ? target_in : inst_pc + 32'd4;
        end else if (stall) begin
            pc_next = pc_q;
        end else if (predict_taken) begin
            pc_next = predict_target;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            if_is_branch_taken <= 1'b0;
            if_pht_index       <= '0;
            if_pc              <= '0;
        end else if (!stall) begin
            if_is_branch_taken <= predict_taken;
            if_pht_index       <= lookup_index;
            if_pc              <= pc_q;
        end
    end

endmodule

// File: tb/tb_pc_stage.sv
// Randomized and directed bench for pc_stage against a behavioural fetch/predictor model.
// Follows PC_STAGE_BRANCH_PREDICT_EN the same way the design does.
module tb_pc_stage;
  localparam int GW = 5;
  localparam int BW = 6;
  localparam logic [31:0] RPC = 32'hBFC00000;
`ifdef PC_STAGE_BRANCH_PREDICT_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, is_branch_in, is_jump_in, is_taken_in, is_miss_in, flush, stall;
  logic [GW-1:0] last_pht_index;
  logic [31:0] inst_pc, target_in, exc_pc;
  logic is_branch_taken, if_is_branch_taken;
  logic [GW-1:0] pht_index_out, if_pht_index;
  logic [31:0] pc_out, if_pc;

  pc_stage #(.GHR_WIDTH(GW), .BTB_INDEX_WIDTH(BW), .RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst), .is_branch_in(is_branch_in), .is_jump_in(is_jump_in),
    .is_taken_in(is_taken_in), .is_miss_in(is_miss_in), .last_pht_index(last_pht_index),
    .inst_pc(inst_pc), .target_in(target_in), .flush(flush), .exc_pc(exc_pc), .stall(stall),
    .is_branch_taken(is_branch_taken), .pht_index_out(pht_index_out), .pc_out(pc_out),
    .if_is_branch_taken(if_is_branch_taken), .if_pht_index(if_pht_index), .if_pc(if_pc)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  // behavioural model: plain integers and arrays, full-PC BTB entries
  bit [31:0] m_pc, m_if_pc;
  bit        m_if_taken;
  int        m_if_idx;
  int        m_ghr;
  int        m_pht [1 << GW];
  bit        m_bv [1 << BW];
  bit [31:0] m_bpc [1 << BW];
  bit [31:0] m_btgt [1 << BW];
  bit        m_bjmp [1 << BW];

  function automatic int slot_of(input bit [31:0] a);
    return int'((a >> 2) % (1 << BW));
  endfunction

  function automatic int m_index();
    if (!EN) return 0;
    return (m_ghr ^ int'((m_pc >> 2) % (1 << GW))) % (1 << GW);
  endfunction

  function automatic bit m_taken();
    int s;
    bit hit;
    if (!EN) return 1'b0;
    s = slot_of(m_pc);
    hit = m_bv[s] && ((m_bpc[s] >> (BW + 2)) == (m_pc >> (BW + 2)));
    return hit && (m_bjmp[s] || m_pht[m_index()] >= 2);
  endfunction

  always @(posedge clk) begin
    if (!rst) begin
      m_pc <= RPC;
      m_if_pc <= '0;
      m_if_taken <= 1'b0;
      m_if_idx <= 0;
      m_ghr <= 0;
      for (int i = 0; i < (1 << GW); i++) m_pht[i] <= 1;
      for (int i = 0; i < (1 << BW); i++) m_bv[i] <= 1'b0;
    end else begin
      if (flush) m_pc <= exc_pc;
      else if (is_miss_in) m_pc <= is_taken_in ? target_in : inst_pc + 32'd4;
      else if (stall) m_pc <= m_pc;
      else if (m_taken()) m_pc <= m_btgt[slot_of(m_pc)];
      else m_pc <= m_pc + 32'd4;

      if (flush) begin
        m_if_pc <= '0;
        m_if_taken <= 1'b0;
        m_if_idx <= 0;
      end else if (!stall) begin
        m_if_pc <= m_pc;
        m_if_taken <= m_taken();
        m_if_idx <= m_index();
      end

      if (EN && is_branch_in && !is_jump_in) begin
        if (is_taken_in) m_pht[last_pht_index] <= (m_pht[last_pht_index] == 3) ? 3 : m_pht[last_pht_index] + 1;
        else m_pht[last_pht_index] <= (m_pht[last_pht_index] == 0) ? 0 : m_pht[last_pht_index] - 1;
        m_ghr <= ((m_ghr << 1) | int'(is_taken_in)) % (1 << GW);
      end
      if (EN && is_branch_in && is_taken_in) begin
        m_bv[slot_of(inst_pc)] <= 1'b1;
        m_bpc[slot_of(inst_pc)] <= inst_pc;
        m_btgt[slot_of(inst_pc)] <= target_in;
        m_bjmp[slot_of(inst_pc)] <= is_jump_in;
      end
    end
  end

  // scoreboard compare: every output, every cycle, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      check("pc_out", pc_out, m_pc);
      check("is_branch_taken", {31'b0, is_branch_taken}, {31'b0, m_taken()});
      check("pht_index_out", {27'b0, pht_index_out}, 32'(m_index()));
      check("if_pc", if_pc, m_if_pc);
      check("if_is_branch_taken", {31'b0, if_is_branch_taken}, {31'b0, m_if_taken});
      check("if_pht_index", {27'b0, if_pht_index}, 32'(m_if_idx));
    end
  end

  // driver tasks
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    is_branch_in = 1'b0; is_jump_in = 1'b0; is_taken_in = 1'b0; is_miss_in = 1'b0;
    last_pht_index = '0; inst_pc = '0; target_in = '0; flush = 1'b0; exc_pc = '0; stall = 1'b0;
  endtask

  function automatic logic [31:0] pick_addr();
    return RPC + 32'($urandom_range(0, 15) << 2) + 32'($urandom_range(0, 1) << (BW + 2));
  endfunction

  int misses;
  int waited;

  initial begin
    clear_inputs();
    rst = 1'b0;
    next_cycle();
    next_cycle();
    chk_en = 1'b1;

    // reset state and sequential fetch
    @(negedge clk);
    check("reset_pc", pc_out, 32'hBFC00000);
    check("reset_if_pc", if_pc, 32'h0);
    rst = 1'b1;
    next_cycle();
    @(negedge clk);
    check("seq_pc1", pc_out, 32'hBFC00004);
    check("seq_if_pc1", if_pc, 32'hBFC00000);
    check("seq_no_pred", {31'b0, is_branch_taken}, 32'h0);
    next_cycle();
    @(negedge clk);
    check("seq_pc2", pc_out, 32'hBFC00008);
    check("seq_if_pc2", if_pc, 32'hBFC00004);

    // loop training: taken branch at BFC00010 back to BFC00000
    misses = 0;
    for (int it = 0; it < 12; it++) begin
      waited = 0;
      while (m_pc != 32'hBFC00010 && waited < 20) begin
        next_cycle();
        waited++;
      end
      check("loop_reach", m_pc, 32'hBFC00010);
      is_branch_in = 1'b1; is_taken_in = 1'b1; inst_pc = 32'hBFC00010;
      target_in = 32'hBFC00000; last_pht_index = GW'(m_index());
      is_miss_in = !m_taken();
      if (is_miss_in) misses++;
      if (it == 11) begin
        @(negedge clk);
        check("loop_final_pred", {31'b0, is_branch_taken}, {31'b0, EN});
      end
      next_cycle();
      clear_inputs();
      @(negedge clk);
      check("loop_redirect", pc_out, 32'hBFC00000);
    end
    check("loop_misses", 32'(misses), EN ? 32'd6 : 32'd12);

    // flush beats a simultaneous miss, then a 3-cycle stall with a miss in its last cycle
    next_cycle();
    flush = 1'b1; exc_pc = 32'hBFC00380; is_miss_in = 1'b1; is_taken_in = 1'b1;
    is_branch_in = 1'b1; inst_pc = 32'hBFC00010; target_in = 32'hBFC00000;
    last_pht_index = GW'(m_index());
    next_cycle();
    clear_inputs();
    stall = 1'b1;
    @(negedge clk);
    check("flush_pc", pc_out, 32'hBFC00380);
    check("flush_if_pc", if_pc, 32'h0);
    next_cycle();
    @(negedge clk);
    check("stall_pc_hold", pc_out, 32'hBFC00380);
    check("stall_if_hold", if_pc, 32'h0);
    next_cycle();
    is_miss_in = 1'b1; is_taken_in = 1'b1; target_in = 32'hBFC00100; inst_pc = 32'hBFC00200;
    @(negedge clk);
    check("stall_pc_hold3", pc_out, 32'hBFC00380);
    next_cycle();
    clear_inputs();
    @(negedge clk);
    check("stall_miss_pc", pc_out, 32'hBFC00100);
    check("stall_miss_if_pc", if_pc, 32'h0);

    // wrap of the sequential PC
    flush = 1'b1; exc_pc = 32'hFFFFFFF8;
    next_cycle();
    clear_inputs();
    next_cycle();
    @(negedge clk);
    check("wrap_top", pc_out, 32'hFFFFFFFC);
    next_cycle();
    @(negedge clk);
    check("wrap_zero", pc_out, 32'h0);

    // randomized traffic, including mid-run resets
    for (int c = 0; c < 1500; c++) begin
      next_cycle();
      rst = ($urandom_range(0, 149) != 0);
      flush = ($urandom_range(0, 29) == 0);
      exc_pc = pick_addr();
      stall = ($urandom_range(0, 4) == 0);
      is_branch_in = ($urandom_range(0, 3) == 0);
      is_jump_in = ($urandom_range(0, 3) == 0);
      is_taken_in = ($urandom_range(0, 2) != 0);
      is_miss_in = ($urandom_range(0, 5) == 0);
      last_pht_index = GW'($urandom_range(0, (1 << GW) - 1));
      inst_pc = ($urandom_range(0, 1) == 0) ? m_pc : pick_addr();
      target_in = pick_addr();
    end
    next_cycle();
    clear_inputs();
    rst = 1'b1;
    next_cycle();
    @(negedge clk);
    chk_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/pc_stage.md
PC_STAGE -- requirements
Module: pc_stage

Interface
REQ-001 The block SHALL have parameter GHR_WIDTH, default 5, giving the global-history width and PHT index width (PHT of 2^GHR_WIDTH 2-bit counters).
REQ-002 The block SHALL have parameter BTB_INDEX_WIDTH, default 6, giving a direct-mapped BTB of 2^BTB_INDEX_WIDTH entries.
REQ-003 The block SHALL have parameter RESET_PC, default 32'hBFC00000, the fetch address after reset.
REQ-004 Ports SHALL be: clk in 1, the single clock; rst in 1, synchronous active-low reset; is_branch_in in 1, resolved control-flow instruction; is_jump_in in 1, resolved instruction is an unconditional jump; is_taken_in in 1, resolved outcome; is_miss_in in 1, prediction was wrong; last_pht_index in GHR_WIDTH, PHT index carried with the resolved instruction; inst_pc in 32, resolved instruction PC; target_in in 32, resolved target; flush in 1, exception redirect; exc_pc in 32, redirect address; stall in 1, hold fetch.
REQ-005 Output ports SHALL be: is_branch_taken out 1, prediction for fetch PC; pht_index_out out GHR_WIDTH, PHT index used; pc_out out 32, current fetch PC; if_is_branch_taken out 1, if_pht_index out GHR_WIDTH, if_pc out 32, registered PC/IF copies.

Function
REQ-006 pc_out SHALL be the PC register; is_branch_taken and pht_index_out SHALL be combinational from pc_out and predictor state in the same cycle.
REQ-007 pht_index_out SHALL equal GHR XOR pc_out[GHR_WIDTH+1:2].
REQ-008 BTB entry SHALL hold valid, tag pc[31:BTB_INDEX_WIDTH+2], target, jump flag; index pc[BTB_INDEX_WIDTH+1:2].
REQ-009 is_branch_taken SHALL be 1 iff BTB hit and (jump flag set or PHT[pht_index_out] >= 2).
REQ-010 Next-PC priority SHALL be: flush -> exc_pc; else is_miss_in -> target_in if is_taken_in else inst_pc+4; else stall -> hold; else is_branch_taken -> BTB target; else pc_out+4 (mod 2^32, wrap from 32'hFFFFFFFC to 0).
REQ-011 When is_branch_in=1 and is_jump_in=0, PHT[last_pht_index] SHALL saturate-increment if is_taken_in else saturate-decrement (bounds 0 and 3).
REQ-012 When is_branch_in=1 and is_taken_in=1, the BTB entry for inst_pc SHALL be written (valid, tag, target_in, jump flag=is_jump_in); not-taken SHALL leave the BTB unchanged.
REQ-013 When is_branch_in=1 and is_jump_in=0, GHR SHALL shift left by one inserting is_taken_in at bit 0; GHR updates only on resolution, never speculatively.
REQ-014 Predictor updates SHALL occur regardless of stall or flush; a same-cycle update and lookup SHALL use pre-update state.
REQ-015 PC/IF register SHALL on each clk: flush -> load zeros; else stall -> hold; else capture is_branch_taken, pht_index_out, pc_out.

Reset
REQ-016 With rst=0 at a clk edge: PC = RESET_PC, GHR = 0, all PHT counters = 1 (weakly not-taken), all BTB valid = 0, PC/IF outputs = 0; reset SHALL override flush, miss, stall.
REQ-017 Reset SHALL be synchronous; rst asserted mid-operation takes effect at the next edge only.

Configuration
REQ-018 Macro PC_STAGE_BRANCH_PREDICT_EN: defined -> predictor per REQ-007..REQ-014; undefined -> no PHT/BTB/GHR storage, is_branch_taken=0, pht_index_out=0, next PC uses only flush, miss and stall redirects, else pc_out+4.

Verification
REQ-019 Reset then release, no events -> pc_out 32'hBFC00000, 32'hBFC00004, ..., if_pc one cycle behind; is_branch_taken=0.
REQ-020 Miss at inst_pc=32'hBFC00010, target 32'hBFC00000, taken, last_pht_index=captured index -> next pc_out 32'hBFC00000; BTB and PHT updated.
REQ-021 Loop 0xBFC00000..0xBFC00010 with REQ-020 miss repeated -> once GHR and counters stabilize, is_branch_taken=1 at 0xBFC00010 and misses cease within 100 cycles.
REQ-022 flush=1, exc_pc=32'hBFC00380, simultaneous is_miss_in=1 -> pc_out 32'hBFC00380; if_pc = 0 next cycle.
REQ-023 stall=1 for 3 cycles -> pc_out and PC/IF outputs hold; is_miss_in during stall still redirects.
REQ-024 Macro undefined, repeated REQ-020 training -> is_branch_taken stays 0, every iteration misses.
